glitch_scheduler: RTL

Sequences fault injection for the clock-glitch datapath. Software first arms the block with a delay, pulse width, pulse count and inter-pulse gap. On a rising edge of the external target trigger, the block waits the programmed delay and then emits a train of glitch-request pulses on glitch_o. glitch_o drives the trig input of the single-cycle clock-glitch module, so each pulse produces one upset.

---
 rtl/glitch_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/glitch_scheduler.sv
// Fault-injection sequencer: after arming, waits a programmed delay from a synchronised
// trigger edge, then emits a train of glitch-request pulses with programmable width and gap.
module glitch_scheduler #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [NUM_W-1:0] cfg_count,
  output logic             glitch_o,
  output logic             armed_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] pulse_idx_o
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [NUM_W-1:0] NumOne = NUM_W'(1);

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StFire, StGap} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] delay_q, delay_d, width_q, width_d, gap_q, gap_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic             s1_q, s2_q, s3_q;
  logic             glitch_q, glitch_d, armed_q, armed_d, busy_q, busy_d, done_q, done_d;
  logic             rise;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    delay_d = delay_q;
    width_d = width_q;
    gap_d   = gap_q;
    count_d = count_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (arm) begin
          state_d = StArmed;
          delay_d = cfg_delay;
          width_d = (cfg_width == '0) ? CntOne : cfg_width;
          gap_d   = (cfg_gap == '0) ? CntOne : cfg_gap;
          count_d = (cfg_count == '0) ? NumOne : cfg_count;
        end
      end
      StArmed: begin
        if (rise) begin
          if (delay_q == '0) begin
            state_d = StFire;
            cnt_d   = width_q;
            idx_d   = idx_q + NumOne;
          end else begin
            state_d = StDelay;
            cnt_d   = delay_q;
          end
        end
      end
      StDelay, StGap: begin
        if (cnt_q == CntOne) begin
          state_d = StFire;
          cnt_d   = width_q;
          idx_d   = idx_q + NumOne;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StFire: begin
        if (cnt_q == CntOne) begin
          if (idx_q == count_q) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
            cnt_d   = gap_q;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; in IDLE it also blocks a coincident arm and config capture.
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      done_d  = 1'b0;
      delay_d = delay_q;
      width_d = width_q;
      gap_d   = gap_q;
      count_d = count_q;
    end

    glitch_d = (state_d == StFire);
    armed_d  = (state_d == StArmed);
    busy_d   = (state_d == StDelay) || (state_d == StFire) || (state_d == StGap);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      delay_q  <= '0;
      width_q  <= '0;
      gap_q    <= '0;
      count_q  <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      glitch_q <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      s1_q     <= trig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      glitch_q <= glitch_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign glitch_o    = glitch_q;
  assign armed_o     = armed_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_idx_o = idx_q;

endmodule
